// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch run/pause/clear controller.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam int DIV_DEFAULT   = 100000;
    localparam int N_DIG_DEFAULT = 3;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Base-tick prescaler: counts 0..DIV-1 while en is high, holds otherwise.
module divisor_tick
    import cronometro_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             W    = clog2_w(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] pre_reg;

    assign tick = en && (pre_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_reg <= '0;
        end else if (en) begin
            pre_reg <= tick ? '0 : pre_reg + W'(1);
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: start/stop FSM, per-digit carry enables, chain clear.
// Build option CRONOMETRO_WRAP_EN: roll over at all-9s instead of stopping in FULL.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int N_DIG = N_DIG_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic [N_DIG-1:0] digit_max,
    output logic [N_DIG-1:0] dig_en,
    output logic             dig_clr,
    output logic             running,
    output logic             overflow
);

    state_t           state_reg;
    logic             dig_clr_reg;
    logic             running_reg;
    logic             overflow_reg;
    logic             run_active;
    logic             tick;
    logic             all_max_evt;
    logic [N_DIG:0]   max_chain;
    logic [N_DIG-1:0] en_raw;

    assign run_active = (state_reg == RUN);

    divisor_tick #(.DIV(DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (run_active),
        .clr   (clear),
        .tick  (tick)
    );

    // Digit i advances when every lower digit is sitting at 9.
    assign max_chain[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_chain
            assign max_chain[gi+1] = max_chain[gi] & digit_max[gi];
            assign en_raw[gi]      = tick & max_chain[gi];
        end
    endgenerate

    assign all_max_evt = tick & max_chain[N_DIG];

`ifdef CRONOMETRO_WRAP_EN
    assign dig_en = en_raw;
`else
    assign dig_en = all_max_evt ? '0 : en_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            dig_clr_reg  <= 1'b0;
            running_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            dig_clr_reg <= clear;
`ifdef CRONOMETRO_WRAP_EN
            overflow_reg <= 1'b0;
`endif
            if (clear) begin
                state_reg    <= IDLE;
                running_reg  <= 1'b0;
                overflow_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_stop) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    RUN: begin
`ifdef CRONOMETRO_WRAP_EN
                        overflow_reg <= all_max_evt;
                        if (start_stop) begin
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                        end
`else
                        // Reaching all-9s takes priority over a simultaneous pause.
                        if (all_max_evt) begin
                            state_reg    <= FULL;
                            running_reg  <= 1'b0;
                            overflow_reg <= 1'b1;
                        end else if (start_stop) begin
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                        end
`endif
                    end
                    PAUSE: begin
                        if (start_stop) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    assign dig_clr  = dig_clr_reg;
    assign running  = running_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Scoreboard bench for cronometro_ctrl with DIV=4, N_DIG=3 and a BCD digit model.
`timescale 1ns/1ps
module tb_cronometro_ctrl;
    import cronometro_pkg::*;

    localparam int DIV   = 4;
    localparam int N_DIG = 3;

    typedef struct {
        int         cyc;
        logic [2:0] en;
        logic       clr;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] digit_max;
    logic [2:0] dig_en;
    logic       dig_clr;
    logic       running;
    logic       overflow;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    logic [3:0] d [3];
    logic preload = 1'b0;

    always #5 clk = ~clk;

    cronometro_ctrl #(.DIV(DIV), .N_DIG(N_DIG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .digit_max  (digit_max),
        .dig_en     (dig_en),
        .dig_clr    (dig_clr),
        .running    (running),
        .overflow   (overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BCD digit counters driven by the controller.
    always @(posedge clk) begin
        if (reset || dig_clr) begin
            for (int i = 0; i < 3; i++) d[i] <= 4'd0;
        end else if (preload) begin
            for (int i = 0; i < 3; i++) d[i] <= 4'd9;
        end else begin
            for (int i = 0; i < 3; i++)
                if (dig_en[i]) d[i] <= (d[i] == 4'd9) ? 4'd0 : d[i] + 4'd1;
        end
    end

    always_comb begin
        digit_max = '0;
        for (int i = 0; i < 3; i++) digit_max[i] = (d[i] == 4'd9);
    end

    // Monitor: every dig_en / dig_clr pulse must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (dig_en != 3'b000 || dig_clr) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse cyc=%0d actual dig_en=%b dig_clr=%b required no pulse",
                         cyc, dig_en, dig_clr);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.en !== dig_en || e.clr !== dig_clr) begin
                    fails++;
                    $display("FAIL pulse actual cyc=%0d dig_en=%b dig_clr=%b required cyc=%0d dig_en=%b dig_clr=%b",
                             cyc, dig_en, dig_clr, e.cyc, e.en, e.clr);
                end else begin
                    $display("pulse ok cyc=%0d dig_en=%b dig_clr=%b", cyc, dig_en, dig_clr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end else begin
            $display("check ok %s cyc=%0d value=%0d", name, cyc, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic push(input int c, input logic [2:0] en, input logic clr);
        ev_t e;
        e.cyc = c;
        e.en  = en;
        e.clr = clr;
        exp_q.push_back(e);
    endtask

    function automatic int count();
        return int'(d[2]) * 100 + int'(d[1]) * 10 + int'(d[0]);
    endfunction

    // Enables for a tick taken while the display reads c (c below 999).
    function automatic logic [2:0] en_for(input int c);
        return {(c % 100) == 99, (c % 10) == 9, 1'b1};
    endfunction

    initial begin
        int s, p, t, c, u;
        repeat (3) step();
        check("reset_dig_en", 32'(dig_en), 0);
        check("reset_dig_clr", 32'(dig_clr), 0);
        check("reset_running", 32'(running), 0);
        check("reset_overflow", 32'(overflow), 0);
        reset = 1'b0;
        step();

        // Start from IDLE: ticks every DIV cycles, count up to 010.
        s = cyc;
        start_stop = 1'b1;
        for (int k = 1; k <= 10; k++) push(s + 4 * k, en_for(k - 1), 1'b0);
        check("running_before_start", 32'(running), 0);
        step();
        start_stop = 1'b0;
        check("running_after_start", 32'(running), 1);
        go_to(s + 41);
        check("count_010", 32'(count()), 10);

        // Pause leaving pre=2, hold 20 cycles, resume: next tick 2 cycles later.
        go_to(s + 42);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        check("running_paused", 32'(running), 0);
        repeat (20) step();
        check("count_held_in_pause", 32'(count()), 10);
        p = cyc;
        start_stop = 1'b1;
        push(p + 2, en_for(10), 1'b0);
        push(p + 6, en_for(11), 1'b0);
        step();
        start_stop = 1'b0;
        check("running_resumed", 32'(running), 1);

        // clear together with start_stop in RUN: clear wins.
        go_to(p + 7);
        clear = 1'b1;
        start_stop = 1'b1;
        push(p + 8, 3'b000, 1'b1);
        step();
        clear = 1'b0;
        start_stop = 1'b0;
        check("running_after_clear", 32'(running), 0);
        step();
        check("dig_clr_one_cycle", 32'(dig_clr), 0);
        check("count_cleared", 32'(count()), 0);
        repeat (12) step();
        check("idle_after_clear", 32'(running), 0);

        // All-nines boundary.
        preload = 1'b1;
        step();
        preload = 1'b0;
        check("count_999", 32'(count()), 999);
        t = cyc;
        start_stop = 1'b1;
`ifdef CRONOMETRO_WRAP_EN
        push(t + 4, 3'b111, 1'b0);
        push(t + 8, 3'b001, 1'b0);
`endif
        step();
        start_stop = 1'b0;
        go_to(t + 5);
`ifdef CRONOMETRO_WRAP_EN
        check("wrap_overflow_pulse", 32'(overflow), 1);
        check("wrap_still_running", 32'(running), 1);
        check("wrap_count_000", 32'(count()), 0);
        step();
        check("wrap_overflow_drop", 32'(overflow), 0);
        go_to(t + 9);
        check("wrap_count_001", 32'(count()), 1);
`else
        check("full_overflow", 32'(overflow), 1);
        check("full_not_running", 32'(running), 0);
        check("full_count_999", 32'(count()), 999);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        repeat (8) step();
        check("full_overflow_level", 32'(overflow), 1);
        check("full_ignores_start", 32'(running), 0);
        check("full_count_frozen", 32'(count()), 999);
`endif
        c = cyc;
        clear = 1'b1;
        push(c + 1, 3'b000, 1'b1);
        step();
        clear = 1'b0;
        check("overflow_cleared", 32'(overflow), 0);
        step();
        check("count_after_overflow_clear", 32'(count()), 0);

        // reset while RUN with pre=3 (tick cycle).
        u = cyc;
        start_stop = 1'b1;
        push(u + 4, 3'b001, 1'b0);
        step();
        start_stop = 1'b0;
        go_to(u + 4);
        reset = 1'b1;
        step();
        check("rst_dig_en", 32'(dig_en), 0);
        check("rst_dig_clr", 32'(dig_clr), 0);
        check("rst_running", 32'(running), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(dut.state_reg), 32'(IDLE));
        check("rst_pre", 32'(dut.u_div.pre_reg), 0);
        reset = 1'b0;
        repeat (10) step();
        check("idle_after_reset", 32'(running), 0);
        check("pending_events", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
